operand_pair_sequencer: RTL
===========================

// Module: operand_pair_sequencer
// PURPOSE
//  Hardware stimulus source for the NBITS equality comparator stage.
//  - Sits directly upstream of the comparator; a_out/b_out drive its a_in/b_in.
//  - Walks every (a,b) operand pair exhaustively: b is the inner loop, a the outer.
//  - Uses a valid/ready handshake so the downstream stage can throttle the walk.
//  - Built-in self-test replacement for long simulation-only exhaustive loops.
// PARAMETERS
//  NBITS  16  operand width; 2**(2*NBITS) pairs per sweep
//  ERR_W  32  width of mismatch counter (used only with CMP_CHECK_EN)
// PORTS
//  clk        in   1          single clock, rising edge
//  reset      in   1          asynchronous, active-high; clears all state
//  start      in   1          begin sweep; sampled in IDLE and DONE only
//  ready      in   1          downstream accepts the current pair
//  a_out      out  NBITS      operand A (outer loop)
//  b_out      out  NBITS      operand B (inner loop)
//  valid      out  1          a_out/b_out hold a pair to transfer
//  busy       out  1          FSM in RUN
//  done       out  1          sweep complete; sticky until next start
//  pair_count out  2*NBITS+1  pairs transferred this sweep; never wraps
//  cmp_out    in   1          comparator result for current pair (CMP_CHECK_EN only)
//  err_count  out  ERR_W      mismatches this sweep (CMP_CHECK_EN only)
//  err_flag   out  1          sticky mismatch seen this sweep (CMP_CHECK_EN only)
// BEHAVIOUR
//  - Reset (async, any time, including mid-sweep):
//    - State -> IDLE.
//    - a_out, b_out, pair_count and err_count -> 0.
//    - valid, busy, done and err_flag -> 0.
//  - FSM states: IDLE, RUN, DONE. All outputs are registered.
//  - IDLE: on start=1, next cycle enters RUN with a=0, b=0, valid=1, busy=1, counters=0.
//  - RUN: a transfer occurs on any edge where valid && ready.
//    - On transfer: pair_count increments.
//    - If b != max: b increments.
//    - Else if a != max: b wraps to 0 and a increments.
//    - Else (a=max, b=max): enter DONE.
//    - valid && !ready: a_out, b_out and valid are held stable; no count change.
//    - start is ignored in RUN.
//  - DONE: valid=0, busy=0, done=1.
//    - a_out/b_out hold the last pair (all ones).
//    - pair_count holds 2**(2*NBITS).
//    - start=1 restarts exactly as from IDLE; done clears in that same cycle.
//  - Latency: first pair valid 1 cycle after start. With ready held high, one pair per cycle.
//    Full sweep occupies RUN for 2**(2*NBITS) cycles.
//  - The downstream comparator is combinational on a_out/b_out.
//    Its result belongs to the pair presented in the same cycle.
// CONFIGURATION
//  CMP_CHECK_EN defined:
//  - cmp_out, err_count and err_flag ports exist.
//  - On each transfer: expected = (a_out == b_out); if cmp_out != expected:
//    - err_count increments, saturating at all ones.
//    - err_flag is set.
//  - Both clear on reset and on an accepted start. Both hold in DONE.
//  CMP_CHECK_EN undefined: those three ports and all check logic are absent; all else is identical.
// TESTING  (NBITS=2 unless noted: 16 pairs)
//  1. Reset, then start pulse, ready=1:
//     - Pairs (0,0),(0,1)..(3,3) appear on consecutive cycles.
//     - done=1 after 16 transfers; pair_count=16.
//  2. Same sweep, ready toggled 1,0,1,0:
//     - Pair held while ready=0; sequence unchanged.
//     - Sweep takes 31 cycles; pair_count=16.
//  3. Assert reset at pair (2,1):
//     - Immediate IDLE; all outputs 0; no done.
//     - New start begins again at (0,0).
//  4. start held high through RUN:
//     - No restart mid-sweep.
//     - In DONE, start re-launches; done drops; pair_count returns to 0 then counts.
//  5. CMP_CHECK_EN, cmp_out from a correct comparator: err_count=0, err_flag=0 at done.
//  6. CMP_CHECK_EN, cmp_out forced 0:
//     - err_count=4 (the diagonal pairs); err_flag=1.
//     - NBITS=16, ERR_W=2: err_count saturates at 3.

Source files
------------

// File: rtl/operand_pair_sequencer.sv
// Exhaustive (a,b) operand-pair walker with valid/ready throttling for the equality comparator stage.
// Optional comparator self-check (mismatch counter and sticky flag) is built when CMP_CHECK_EN is defined.
module operand_pair_sequencer #(
  parameter int NBITS = 16,
  parameter int ERR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ready,
  output logic [NBITS-1:0]   a_out,
  output logic [NBITS-1:0]   b_out,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [2*NBITS:0]   pair_count
`ifdef CMP_CHECK_EN
  ,
  input  logic               cmp_out,
  output logic [ERR_W-1:0]   err_count,
  output logic               err_flag
`endif
);

  localparam int CW = 2*NBITS + 1;
  localparam logic [NBITS-1:0] OP_ONE  = NBITS'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    pair_count_q, pair_count_d;
  logic             xfer;

`ifdef CMP_CHECK_EN
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_flag_q, err_flag_d;
  logic             expected_eq;
`else
  localparam int unused_err_w = ERR_W;
`endif

  assign xfer = valid_q && ready;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pair_count_d = pair_count_q;
`ifdef CMP_CHECK_EN
    err_count_d  = err_count_q;
    err_flag_d   = err_flag_q;
    expected_eq  = (a_q == b_q);
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          a_d          = '0;
          b_d          = '0;
          valid_d      = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pair_count_d = '0;
`ifdef CMP_CHECK_EN
          err_count_d  = '0;
          err_flag_d   = 1'b0;
`endif
        end
      end

      ST_RUN: begin
        if (xfer) begin
          pair_count_d = pair_count_q + CNT_ONE;
`ifdef CMP_CHECK_EN
          // cmp_out is combinational on the pair being transferred this cycle
          if (cmp_out != expected_eq) begin
            err_flag_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_ONE;
            end
          end
`endif
          if (b_q != '1) begin
            b_d = b_q + OP_ONE;
          end else if (a_q != '1) begin
            b_d = '0;
            a_d = a_q + OP_ONE;
          end else begin
            // last pair accepted: a/b stay at all ones as the final pair
            state_d = ST_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        a_d     = '0;
        b_d     = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pair_count_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pair_count_q <= pair_count_d;
    end
  end

`ifdef CMP_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign err_count = err_count_q;
  assign err_flag  = err_flag_q;
`endif

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pair_count = pair_count_q;

endmodule
